fclass_pipe: RTL and testbench
==============================

// Module: fclass_pipe
// PURPOSE
//   Parametrised, pipelined FCLASS unit for the FPU. Classifies one FLEN-wide
//   operand per cycle: either a wide (EXPWIDTH/SIGWIDTH) operand or a
//   NaN-boxed narrow (NEXPWIDTH/NSIGWIDTH) operand.
//   Returns the 10-bit one-hot class mask, zero-extended to XLEN.
//   Sits between the FP issue stage and integer writeback, with valid/ready
//   handshakes on both sides and a tag passed through for writeback routing.
// PARAMETERS
//   EXPWIDTH   11  wide-format exponent bits
//   SIGWIDTH   53  wide-format sign+fraction bits; FLEN = EXPWIDTH+SIGWIDTH
//   NEXPWIDTH  8   narrow-format exponent bits
//   NSIGWIDTH  24  narrow-format sign+fraction bits; NLEN = NEXPWIDTH+NSIGWIDTH <= FLEN
//   XLEN       64  result width, must be >= 10
//   TAGW       5   passthrough tag width (destination register index)
// PORTS
//   clk        in   1     clock, all state updates on rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     operand valid
//   in_ready   out  1     unit can accept the operand this cycle
//   in_fmt     in   1     0 = wide format, 1 = narrow format (NaN-boxed)
//   in_frs     in   FLEN  operand register contents
//   in_tag     in   TAGW  tag, returned unchanged with the result
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer accepts the result
//   out_class  out  XLEN  class mask, bits XLEN-1:10 always zero
//   out_tag    out  TAGW  tag of the result
// BEHAVIOUR
//   - Reset: s1_valid, s2_valid and out_valid are 0, and in_ready is 1.
//     out_class and out_tag are 0. Reset is asynchronous and can be asserted
//     at any cycle; in-flight ops are dropped and no partial result appears.
//   - Stage 1, on acceptance (in_valid & in_ready):
//     - Select the format fields.
//     - Narrow mode: the operand is boxed iff in_frs[FLEN-1:NLEN] is all ones.
//       An unboxed operand is classified as the canonical quiet NaN.
//     - Register sign, exp_all0, exp_all1, frac_zero, frac_msb and tag.
//   - Stage 2: build the one-hot mask from the stage-1 flags and register it
//     with the tag. Bit definitions:
//     b0 -inf; b1 -normal; b2 -subnormal; b3 -0; b4 +0; b5 +subnormal;
//     b6 +normal; b7 +inf; b8 signalling NaN (frac_msb=0, frac!=0);
//     b9 quiet NaN (frac_msb=1). The NaN bits ignore the sign.
//   - Exactly one bit is set in every valid result.
//   - Latency and throughput: accept in cycle N -> out_valid in cycle N+2
//     when there is no backpressure. Sustained throughput is 1 op/cycle.
//   - Handshake:
//     - s2_ready = !s2_valid | out_ready
//     - in_ready = !s1_valid | s2_ready
//     - A stage advances only when its downstream is ready.
//     - While out_valid=1 and out_ready=0, out_class and out_tag stay stable.
//     - in_ready must not depend combinationally on in_valid.
//   - Full: with both stages valid and out_ready=0, in_ready=0. No op is
//     lost or duplicated.
//   - Same-cycle accept and drain: when out_valid & out_ready coincide with
//     in_valid & in_ready, both transfers complete, and the pipeline stays full
//     without a bubble.
//   - out_valid=0: out_class and out_tag keep their last values. The consumer
//     must not use them.
//   - in_fmt is X-tolerant only when in_valid=0.
// TESTING
//   T1 wide -inf:
//      fmt=0, frs=0xFFF0_0000_0000_0000, tag=3
//      -> 2 cycles later out_class=0x001, out_tag=3
//   T2 narrow boxed 1.0 and unboxed:
//      frs=0xFFFF_FFFF_3F80_0000 -> 0x040
//      frs=0x0000_0000_3F80_0000 -> 0x200 (unboxed = canonical qNaN)
//   T3 wide NaNs and subnormal:
//      0x7FF0_0000_0000_0001 -> 0x100
//      0x7FF8_0000_0000_0000 -> 0x200
//      0x8000_0000_0000_0001 -> 0x004
//      0x0000_0000_0000_0000 -> 0x010
//   T4 backpressure:
//      - Stream tags 1..5 with in_valid=1 and hold out_ready=0.
//      - After the first two accepts in_ready=0; out_tag=1 stays stable.
//      - Release out_ready: tags return 1..5 in order, none lost or repeated.
//   T5 back-to-back throughput:
//      - 16 random ops with out_ready=1 continuously
//      - -> 16 results on consecutive cycles
//      - each result matches the reference model and has exactly one bit set.
//   T6 reset mid-operation:
//      - Assert rst_n=0 between clock edges with both stages full.
//      - out_valid=0 and in_ready=1 immediately.
//      - No stale result appears after reset is released.

Source files
------------

// File: rtl/fclass_pipe.sv
// Purpose     : two-stage FCLASS unit; classifies a wide or NaN-boxed narrow FP operand into a 10-bit one-hot mask.
// Latency     : 2 cycles from accept to out_valid, 1 op/cycle sustained.
// Backpressure: valid/ready per stage; a stage holds when its downstream is stalled; in_ready is independent of in_valid.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             operand handshake (in_fmt, in_frs, in_tag)
//   in_fmt                        0 = wide format, 1 = narrow NaN-boxed format
//   out_valid/out_ready           result handshake (out_class, out_tag)
//   out_class                     one-hot class mask in bits 9:0, upper bits zero
module fclass_pipe #(
    parameter int EXPWIDTH  = 11,
    parameter int SIGWIDTH  = 53,
    parameter int NEXPWIDTH = 8,
    parameter int NSIGWIDTH = 24,
    parameter int XLEN      = 64,
    parameter int TAGW      = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_fmt,
    input  logic [EXPWIDTH+SIGWIDTH-1:0] in_frs,
    input  logic [TAGW-1:0]              in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_class,
    output logic [TAGW-1:0]              out_tag
);
    localparam int FLEN = EXPWIDTH + SIGWIDTH;
    localparam int NLEN = NEXPWIDTH + NSIGWIDTH;

    // Pipeline control
    logic s1_valid;
    logic s2_valid;
    logic s2_ready;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    // Stage-1 field decode
    logic sel_sign, sel_exp0, sel_exp1, sel_fzero, sel_fmsb;

    always_comb begin
        sel_sign  = 1'b0;
        sel_exp0  = 1'b0;
        sel_exp1  = 1'b0;
        sel_fzero = 1'b0;
        sel_fmsb  = 1'b0;
        if (in_fmt) begin
            if (&in_frs[FLEN-1:NLEN]) begin
                sel_sign  = in_frs[NLEN-1];
                sel_exp0  = ~|in_frs[NLEN-2 -: NEXPWIDTH];
                sel_exp1  = &in_frs[NLEN-2 -: NEXPWIDTH];
                sel_fzero = ~|in_frs[NSIGWIDTH-2:0];
                sel_fmsb  = in_frs[NSIGWIDTH-2];
            end else begin
                // Improperly boxed narrow value reads as the canonical quiet NaN
                sel_sign  = 1'b0;
                sel_exp0  = 1'b0;
                sel_exp1  = 1'b1;
                sel_fzero = 1'b0;
                sel_fmsb  = 1'b1;
            end
        end else begin
            sel_sign  = in_frs[FLEN-1];
            sel_exp0  = ~|in_frs[FLEN-2 -: EXPWIDTH];
            sel_exp1  = &in_frs[FLEN-2 -: EXPWIDTH];
            sel_fzero = ~|in_frs[SIGWIDTH-2:0];
            sel_fmsb  = in_frs[SIGWIDTH-2];
        end
    end

    // Stage-1 registers
    logic            s1_sign, s1_exp0, s1_exp1, s1_fzero, s1_fmsb;
    logic [TAGW-1:0] s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp0  <= 1'b0;
            s1_exp1  <= 1'b0;
            s1_fzero <= 1'b0;
            s1_fmsb  <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            // Payload only loads on a real transfer so in_fmt may be X while idle
            if (in_valid && in_ready) begin
                s1_sign  <= sel_sign;
                s1_exp0  <= sel_exp0;
                s1_exp1  <= sel_exp1;
                s1_fzero <= sel_fzero;
                s1_fmsb  <= sel_fmsb;
                s1_tag   <= in_tag;
            end
        end
    end

    // Stage-2 mask build
    logic [9:0] mask;

    always_comb begin
        mask = 10'd0;
        if (s1_exp1) begin
            if (s1_fzero)     mask[s1_sign ? 0 : 7] = 1'b1;
            else if (s1_fmsb) mask[9] = 1'b1;
            else              mask[8] = 1'b1;
        end else if (s1_exp0) begin
            if (s1_fzero)     mask[s1_sign ? 3 : 4] = 1'b1;
            else              mask[s1_sign ? 2 : 5] = 1'b1;
        end else begin
            mask[s1_sign ? 1 : 6] = 1'b1;
        end
    end

    // Stage-2 registers; payload holds while stalled or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_class <= '0;
            out_tag   <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_ready) begin
                out_class <= XLEN'(mask);
                out_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fclass_pipe.sv
module tb_fclass_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_fmt;
    logic [63:0] in_frs;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_class;
    logic [4:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fclass_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_frs    (in_frs),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent classifier for the default 64/32-bit formats
    function automatic logic [9:0] ref_class(input logic fmt, input logic [63:0] v);
        logic        s;
        logic        emax, emin, fz, q;
        if (fmt) begin
            if (v[63:32] != 32'hFFFF_FFFF) return 10'h200;
            s    = v[31];
            emax = (v[30:23] == 8'hFF);
            emin = (v[30:23] == 8'h00);
            fz   = (v[22:0] == 23'd0);
            q    = v[22];
        end else begin
            s    = v[63];
            emax = (v[62:52] == 11'h7FF);
            emin = (v[62:52] == 11'h000);
            fz   = (v[51:0] == 52'd0);
            q    = v[51];
        end
        if (emax && !fz) return q ? 10'h200 : 10'h100;
        if (emax)        return s ? 10'h001 : 10'h080;
        if (emin && fz)  return s ? 10'h008 : 10'h010;
        if (emin)        return s ? 10'h004 : 10'h020;
        return s ? 10'h002 : 10'h040;
    endfunction

    // Single isolated op: checks latency and result
    task automatic single(input string name, input logic fmt, input logic [63:0] frs,
                          input logic [4:0] tag, input logic [9:0] exp);
        in_valid = 1'b1; in_fmt = fmt; in_frs = frs; in_tag = tag;
        tick();
        in_valid = 1'b0; in_fmt = 1'bx;
        check({name, "_lat1"}, {63'd0, out_valid}, 64'd0);
        tick();
        check({name, "_vld"}, {63'd0, out_valid}, 64'd1);
        check({name, "_cls"}, out_class, {54'd0, exp});
        check({name, "_tag"}, {59'd0, out_tag}, {59'd0, tag});
        tick();
    endtask

    initial begin
        int          nxt, got;
        int          rec[8];
        logic        acc;
        logic [9:0]  expq[$];
        logic [9:0]  e;
        logic [63:0] v;
        logic        f;

        rst_n = 1'b0; in_valid = 1'b0; in_fmt = 1'b0; in_frs = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_class", out_class, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        rst_n = 1'b1;
        tick();

        // T1..T3 and extra directed classes
        single("t1_wneginf", 1'b0, 64'hFFF0_0000_0000_0000, 5'd3, 10'h001);
        single("t2_nbox1",   1'b1, 64'hFFFF_FFFF_3F80_0000, 5'd4, 10'h040);
        single("t2_nunbox",  1'b1, 64'h0000_0000_3F80_0000, 5'd5, 10'h200);
        single("t2_npartbox",1'b1, 64'hFFFF_FFFE_0000_0000, 5'd6, 10'h200);
        single("t3_wsnan",   1'b0, 64'h7FF0_0000_0000_0001, 5'd7, 10'h100);
        single("t3_wqnan",   1'b0, 64'h7FF8_0000_0000_0000, 5'd8, 10'h200);
        single("t3_wnegsub", 1'b0, 64'h8000_0000_0000_0001, 5'd9, 10'h004);
        single("t3_wposz",   1'b0, 64'h0000_0000_0000_0000, 5'd10, 10'h010);
        single("x_wnegz",    1'b0, 64'h8000_0000_0000_0000, 5'd11, 10'h008);
        single("x_wposinf",  1'b0, 64'h7FF0_0000_0000_0000, 5'd12, 10'h080);
        single("x_wnegnorm", 1'b0, 64'hBFF0_0000_0000_0000, 5'd13, 10'h002);
        single("x_nnegz",    1'b1, 64'hFFFF_FFFF_8000_0000, 5'd14, 10'h008);
        single("x_nsnan",    1'b1, 64'hFFFF_FFFF_7F80_0001, 5'd15, 10'h100);
        single("x_npossub",  1'b1, 64'hFFFF_FFFF_0000_0001, 5'd16, 10'h020);
        single("x_nneginf",  1'b1, 64'hFFFF_FFFF_FF80_0000, 5'd17, 10'h001);

        // T4 backpressure
        out_ready = 1'b0; nxt = 1; got = 0;
        in_fmt = 1'b0; in_frs = 64'h3FF0_0000_0000_0000;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_tag = 5'(nxt);
            #1;
            check("t4_fill_rdy", {63'd0, in_ready}, 64'd1);
            tick();
            nxt++;
        end
        in_tag = 5'(nxt);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_full_rdy", {63'd0, in_ready}, 64'd0);
            check("t4_hold_vld", {63'd0, out_valid}, 64'd1);
            check("t4_hold_tag", {59'd0, out_tag}, 64'd1);
            check("t4_hold_cls", out_class, 64'h040);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            in_valid = (nxt <= 5); in_tag = 5'(nxt);
            #1;
            if (out_valid) begin
                if (got < 8) rec[got] = int'(out_tag);
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) nxt++;
            if (nxt > 5 && !out_valid) break;
        end
        in_valid = 1'b0;
        check("t4_count", 64'(got), 64'd5);
        for (int k = 0; k < 5; k++) check("t4_order", 64'(rec[k]), 64'(k + 1));
        for (int c = 0; c < 3; c++) begin
            check("t4_drained", {63'd0, out_valid}, 64'd0);
            tick();
        end

        // T5 back-to-back random ops
        for (int c = 0; c < 19; c++) begin
            check("t5_vld", {63'd0, out_valid}, {63'd0, (c >= 2 && c <= 17)});
            if (out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 10'h3FF;
                check("t5_cls", out_class, {54'd0, e});
                check("t5_onehot", 64'($countones(out_class)), 64'd1);
            end
            if (c < 16) begin
                f = 1'($urandom_range(0, 1));
                v = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0: if (f) v[30:23] = 8'h00;  else v[62:52] = 11'h000;
                    1: if (f) v[30:23] = 8'hFF;  else v[62:52] = 11'h7FF;
                    2: if (f) v[22:0]  = 23'd0;  else v[51:0]  = 52'd0;
                    default: ;
                endcase
                if (f && $urandom_range(0, 3) != 0) v[63:32] = 32'hFFFF_FFFF;
                in_valid = 1'b1; in_fmt = f; in_frs = v; in_tag = 5'(c);
                expq.push_back(ref_class(f, v));
                #1;
                check("t5_rdy", {63'd0, in_ready}, 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end

        // T6 reset with both stages full
        out_ready = 1'b0;
        in_fmt = 1'b0; in_frs = 64'hFFF0_0000_0000_0000;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_tag = 5'(20 + c);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("t6_pre_full", {62'd0, out_valid, in_ready}, 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", {63'd0, out_valid}, 64'd0);
        check("t6_rst_rdy", {63'd0, in_ready}, 64'd1);
        check("t6_rst_tag", {59'd0, out_tag}, 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t6_no_stale", {63'd0, out_valid}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
